// File: rtl/console_uart_tx.sv
// Snoops core stores: console-address bytes are queued and sent as 8N1 on tx; halt-address stores raise halt after drain.
// Latency: tx start bit begins one edge after the capturing edge; halt rises one edge after the last stop bit ends.
// Backpressure: none toward the core; a full FIFO drops the byte and sets sticky overflow. CONSOLE_ECHO_EN adds a sim echo.
`timescale 1ns/1ps

package console_uart_pkg;
    localparam int word_address_size = 32;

    typedef struct packed {
        logic                         valid;
        logic [word_address_size-1:0] addr;
        logic [3:0]                   do_write;
        logic [31:0]                  data;
    } memory_io_req;
endpackage

module console_uart_tx
    import console_uart_pkg::*;
#(
    parameter int                           CLKS_PER_BIT = 16,
    parameter int                           FIFO_DEPTH   = 16,
    parameter logic [word_address_size-1:0] CONSOLE_ADDR = word_address_size'(32'h0002_FFF8),
    parameter logic [word_address_size-1:0] HALT_ADDR    = word_address_size'(32'h0002_FFFC)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  memory_io_req                data_mem_req,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        halt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d;

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          fifo_empty, fifo_full;
    logic          console_wr, halt_wr, push, pop, bit_end;
    logic          halt_pending;
    logic          unused_req_bits;

    assign unused_req_bits = ^data_mem_req.data[31:8];

    assign console_wr = data_mem_req.valid && (data_mem_req.addr == CONSOLE_ADDR) && (|data_mem_req.do_write);
    assign halt_wr    = data_mem_req.valid && (data_mem_req.addr == HALT_ADDR)    && (|data_mem_req.do_write);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign fifo_count = wr_ptr - rd_ptr;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push       = console_wr && (!fifo_full || pop);
    assign busy       = !fifo_empty || (state_q != IDLE);
    assign bit_end    = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr[AW-1:0]];
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr[AW-1:0]];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        // tx is registered from the next state so the line never glitches on decode.
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shift_d[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            halt_pending <= 1'b0;
            halt         <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (console_wr && !push) overflow <= 1'b1;
            if (halt_wr) halt_pending <= 1'b1;
            if (halt_pending && fifo_empty && (state_q == IDLE)) halt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_mem_req.data[7:0];
    end

`ifdef CONSOLE_ECHO_EN
    always @(posedge clk) begin
        if (reset && push) $write("%c", data_mem_req.data[7:0]);
    end
`else
`endif

endmodule

// File: doc/console_uart_tx.md
# console_uart_tx

Memory-mapped console output stage that sits downstream of the core's data-memory request port, alongside the data memory. It snoops `data_mem_req`, captures byte writes to the console address into a FIFO, and serialises them as 8N1 UART frames on `tx`. It also owns program-end signalling: a write to the halt address raises `halt` only after every queued console byte has fully left the wire.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 16: byte FIFO entries; must be a power of 2.
- `CONSOLE_ADDR`, `word_address_size'h0002_FFF8`: console data address.
- `HALT_ADDR`, `word_address_size'h0002_FFFC`: halt address.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_mem_req`  in  memory_io_req  snooped core request; uses `valid`, `addr`, `do_write`, `data`.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in flight.
- `overflow`  out  1  sticky; set when a console write is dropped because the FIFO is full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `halt`  out  1  level; stays high once asserted, until reset.

## Operation
- Console write: `valid && addr == CONSOLE_ADDR && do_write != 0`. Byte `data[7:0]` is pushed at that edge.
- Halt write: same rule with `HALT_ADDR`. It sets an internal `halt_pending` flag.
- Requests with `do_write == 0`, including reads, are ignored. So are requests to any other address.
- Full FIFO on a console write: the byte is dropped and `overflow` is set.
- If the FIFO is full and a pop happens in the same cycle, the push is accepted.
- Console writes after `halt_pending` is set are still queued and transmitted.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles. A 3-bit bit index wraps 7→0 on exit to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles. If the FIFO is non-empty at the end of STOP, pop and go directly to START. Otherwise go to IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and resets on every bit boundary.
- FIFO uses circular read and write pointers with an extra wrap bit. Empty when the pointers are equal; full when they differ only in the MSB.
- `busy` = FIFO non-empty OR FSM ≠ IDLE.
- `halt` is set at the edge where `halt_pending` holds, the FIFO is empty, and the FSM is IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, `halt`=0. FSM goes to IDLE and the FIFO and pointers are cleared.
- Reset takes effect immediately and asynchronously, including mid-frame. The partial frame is abandoned.
- Edge N samples a console write. Edge N+1 pops the byte and enters START, so `tx` falls after edge N+1.
- One frame lasts 10·`CLKS_PER_BIT` cycles. Back-to-back frames have zero idle cycles between them.
- `fifo_count` reflects push and pop at the same edge they occur.
- `halt` rises on the first edge after the final stop bit completes with the FIFO empty. If nothing is queued, it rises on the edge after the halt write.

## Configuration
- `CONSOLE_ECHO_EN` defined: each accepted console byte is also printed with `$write("%c", byte)` at capture time. This is simulation only and does not change the hardware.
- `CONSOLE_ECHO_EN` undefined: no simulation output; the block is behaviour-only.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=16.
- Reset: assert `reset`=0 -> `tx`=1, `busy`=0, `halt`=0, `overflow`=0, `fifo_count`=0.
- Single byte: write 0x41 to 0x2FFF8 -> `tx`=0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop high for 4 cycles. Total 40 cycles, after which `busy` falls.
- Back-to-back: writes 0x48 and 0x69 on consecutive cycles -> two frames spanning exactly 80 cycles with no idle gap. A write with `do_write`=0 in between is ignored.
- Overflow: 18 writes on consecutive cycles -> the first 17 are accepted (1 in the shifter, 16 queued). The 18th is dropped, `overflow`=1, and `fifo_count` peaks at 16.
- Halt drain: 3 bytes queued, then a write to 0x2FFFC -> `halt` stays 0 until the third stop bit ends, then goes to 1 and holds. A halt write with an empty FIFO gives `halt`=1 on the next edge.
- Mid-frame reset: `reset`=0 during DATA -> `tx`=1 immediately, FIFO cleared, `overflow` and `halt` cleared. After release, a new write produces a clean frame.
